load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have clk  input  1  sole clock, rising edge.
REQ-002 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ena  input  1  stage advance permitted (downstream free).
REQ-004 SHALL have free  output  1  unit can accept a new operation.
REQ-005 SHALL have in_valid  input  1  operation from execute stage valid.
REQ-006 SHALL have in_load / in_store  input  1 each  memory operation kind.
REQ-007 SHALL have in_funct3  input  3  access size [1:0] (0=B,1=H,2=W,3=D); [2]=unsigned load.
REQ-008 SHALL have in_addr / in_wdata / in_result  input  64 each  effective address, store data, ALU result.
REQ-009 SHALL have in_rdaddr  input  5  destination register.
REQ-010 SHALL have out_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have out_rdaddr  output  5 and out_data  output  64  writeback target and value.
REQ-012 SHALL have dcache_r_rqst/addr(64)/bits(3) outputs and dcache_r_done/data(64) inputs.
REQ-013 SHALL have dcache_w_rqst/addr(64)/bits(3)/data(64) outputs and dcache_w_done input.

Function
REQ-014 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
REQ-015 SHALL accept an operation on a rising edge where ena & free & in_valid; free = (state==IDLE).
REQ-016 Non-memory operation SHALL produce out_valid the next cycle, out_data=in_result, out_rdaddr=in_rdaddr.
REQ-017 Accepted load SHALL go IDLE->RD_ISSUE; store IDLE->WR_ISSUE; in_load & in_store both high SHALL be treated as a load.
REQ-018 dcache_*_rqst SHALL be high for exactly the one cycle spent in *_ISSUE, then state SHALL move to *_WAIT.
REQ-019 dcache_*_addr SHALL equal the captured in_addr and dcache_*_bits the captured in_funct3 while in ISSUE and WAIT.
REQ-020 *_done SHALL be honoured only in the matching *_WAIT state; done in any other state SHALL be ignored.
REQ-021 On done in WAIT: state SHALL go IDLE and out_valid SHALL pulse the following cycle.
REQ-022 Load data SHALL be right-aligned; out_data SHALL be r_data[7:0]/[15:0]/[31:0] sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1); size D returns all 64 bits regardless of funct3[2].
REQ-023 Store dcache_w_data SHALL be in_wdata with bits above access size forced to zero.
REQ-024 Store completion SHALL pulse out_valid with out_rdaddr=0, out_data=0.
REQ-025 Minimum load/store latency from accept to out_valid SHALL be 3 cycles (ISSUE, WAIT with done, output).
REQ-026 A new operation SHALL be acceptable in the same cycle out_valid is high.
REQ-027 out_data/out_rdaddr SHALL hold last values when out_valid is low.

Reset
REQ-028 On rst: state=IDLE, out_valid=0, out_rdaddr=0, out_data=0, all rqst=0, addr/bits/w_data=0, free=1, immediately and asynchronously.
REQ-029 Reset during RD_WAIT/WR_WAIT SHALL abandon the access; a done arriving after rst release SHALL be ignored.

Structure
REQ-030 Size/extension funct3 constants and the ma_in_t/ma_out_t structs SHALL live in shared package pipeline_pkg.
REQ-031 Load extension SHALL be sub-module load_ext (combinational: data, funct3 -> 64-bit result).

Verification
REQ-032 Load LB addr 0x1000, r_data=0x80 after 2 waiting cycles -> single r_rqst pulse, r_bits=0, out_data=0xFFFFFFFFFFFFFF80, out_valid once.
REQ-033 Load LWU, r_data=0xDEADBEEF_87654321 -> out_data=0x0000000087654321.
REQ-034 Store SH wdata=0x123456789ABC addr 0x2002 -> w_rqst one cycle, w_bits=1, w_data=0x9ABC, free low until w_done.
REQ-035 Back-to-back ALU ops result 5 then 7 -> out_valid two consecutive cycles with data 5, 7.
REQ-036 Spurious r_done in IDLE, then rst asserted in RD_WAIT followed by done -> no out_valid, outputs zero, free=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared memory-access stage types: access-size encodings, stage in/out structs
// and the load/store unit state encoding.
package pipeline_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;
   localparam int unsigned F3_UNSIGNED = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_WR_WAIT  = 3'd4
   } lsu_state_t;

   typedef struct packed {
      logic        valid;
      logic        load;
      logic        store;
      logic [2:0]  funct3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] result;
      logic [4:0]  rdaddr;
   } ma_in_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rdaddr;
      logic [63:0] data;
   } ma_out_t;

   // Bits covered by an access of the given size.
   function automatic logic [63:0] size_mask(input logic [1:0] size);
      logic [63:0] mask;
      case (size)
         SIZE_B:  mask = 64'h0000_0000_0000_00FF;
         SIZE_H:  mask = 64'h0000_0000_0000_FFFF;
         SIZE_W:  mask = 64'h0000_0000_FFFF_FFFF;
         SIZE_D:  mask = 64'hFFFF_FFFF_FFFF_FFFF;
         default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/load_ext.sv
// Right-aligned load data extension: picks the low byte/half/word and sign- or
// zero-extends it to 64 bits; doubleword loads pass through untouched.
module load_ext
   import pipeline_pkg::*;
(
   input  logic [63:0] data,
   input  logic [2:0]  funct3,
   output logic [63:0] result
);

   logic uns_s;

   assign uns_s = funct3[F3_UNSIGNED];

   // Size-dependent extension of the returned cache data.
   always_comb begin
      result = data;
      case (funct3[1:0])
         SIZE_B:  result = uns_s ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
         SIZE_H:  result = uns_s ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
         SIZE_W:  result = uns_s ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
         SIZE_D:  result = data;
         default: result = data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access pipeline stage: passes ALU results through in one cycle and
// sequences single-outstanding loads/stores against the data cache.
module load_store_unit
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   output logic        free,
   input  logic        in_valid,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [2:0]  in_funct3,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   input  logic [63:0] in_result,
   input  logic [4:0]  in_rdaddr,
   output logic        out_valid,
   output logic [4:0]  out_rdaddr,
   output logic [63:0] out_data,
   output logic        dcache_r_rqst,
   output logic [63:0] dcache_r_addr,
   output logic [2:0]  dcache_r_bits,
   input  logic        dcache_r_done,
   input  logic [63:0] dcache_r_data,
   output logic        dcache_w_rqst,
   output logic [63:0] dcache_w_addr,
   output logic [2:0]  dcache_w_bits,
   output logic [63:0] dcache_w_data,
   input  logic        dcache_w_done
);

   lsu_state_t  state_r;
   lsu_state_t  state_next_s;
   ma_in_t      op_s;
   ma_out_t     out_r;
   logic        accept_s;
   logic        free_r;
   logic        r_rqst_r;
   logic        w_rqst_r;
   logic [63:0] addr_r;
   logic [2:0]  funct3_r;
   logic [63:0] wdata_r;
   logic [4:0]  rdaddr_r;
   logic [63:0] ld_data_s;

   // Bundle the execute-stage inputs into the stage input record.
   always_comb begin
      op_s        = '0;
      op_s.valid  = in_valid;
      op_s.load   = in_load;
      op_s.store  = in_store;
      op_s.funct3 = in_funct3;
      op_s.addr   = in_addr;
      op_s.wdata  = in_wdata;
      op_s.result = in_result;
      op_s.rdaddr = in_rdaddr;
   end

   // free_r mirrors (state_r == ST_IDLE), so acceptance only happens in IDLE.
   assign accept_s = ena & free_r & op_s.valid;

   load_ext u_load_ext (
      .data   (dcache_r_data),
      .funct3 (funct3_r),
      .result (ld_data_s)
   );

   // Next-state logic; a simultaneous load+store is handled as a load.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && op_s.load) begin
               state_next_s = ST_RD_ISSUE;
            end else if (accept_s && op_s.store) begin
               state_next_s = ST_WR_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RD_ISSUE: state_next_s = ST_RD_WAIT;
         ST_RD_WAIT:  state_next_s = dcache_r_done ? ST_IDLE : ST_RD_WAIT;
         ST_WR_ISSUE: state_next_s = ST_WR_WAIT;
         ST_WR_WAIT:  state_next_s = dcache_w_done ? ST_IDLE : ST_WR_WAIT;
         default:     state_next_s = ST_IDLE;
      endcase
   end

   // State register plus request/free flags registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         free_r   <= 1'b1;
         r_rqst_r <= 1'b0;
         w_rqst_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         free_r   <= (state_next_s == ST_IDLE);
         r_rqst_r <= (state_next_s == ST_RD_ISSUE);
         w_rqst_r <= (state_next_s == ST_WR_ISSUE);
      end
   end

   // Capture the memory operation; store data is trimmed to the access size.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r   <= 64'd0;
         funct3_r <= 3'd0;
         wdata_r  <= 64'd0;
         rdaddr_r <= 5'd0;
      end else if ((state_r == ST_IDLE) && accept_s && (op_s.load || op_s.store)) begin
         addr_r   <= op_s.addr;
         funct3_r <= op_s.funct3;
         wdata_r  <= op_s.wdata & size_mask(op_s.funct3[1:0]);
         rdaddr_r <= op_s.rdaddr;
      end
   end

   // Writeback pulse; data and target hold between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r <= '0;
      end else begin
         out_r.valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s && !op_s.load && !op_s.store) begin
                  out_r.valid  <= 1'b1;
                  out_r.rdaddr <= op_s.rdaddr;
                  out_r.data   <= op_s.result;
               end
            end
            ST_RD_WAIT: begin
               if (dcache_r_done) begin
                  out_r.valid  <= 1'b1;
                  out_r.rdaddr <= rdaddr_r;
                  out_r.data   <= ld_data_s;
               end
            end
            ST_WR_WAIT: begin
               if (dcache_w_done) begin
                  out_r.valid  <= 1'b1;
                  out_r.rdaddr <= 5'd0;
                  out_r.data   <= 64'd0;
               end
            end
            default: out_r.valid <= 1'b0;
         endcase
      end
   end

   assign free          = free_r;
   assign out_valid     = out_r.valid;
   assign out_rdaddr    = out_r.rdaddr;
   assign out_data      = out_r.data;
   assign dcache_r_rqst = r_rqst_r;
   assign dcache_r_addr = addr_r;
   assign dcache_r_bits = funct3_r;
   assign dcache_w_rqst = w_rqst_r;
   assign dcache_w_addr = addr_r;
   assign dcache_w_bits = funct3_r;
   assign dcache_w_data = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level reference
// model of load extension, store masking and completion timing.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        free;
   logic        in_valid, in_load, in_store;
   logic [2:0]  in_funct3;
   logic [63:0] in_addr, in_wdata, in_result;
   logic [4:0]  in_rdaddr;
   logic        out_valid;
   logic [4:0]  out_rdaddr;
   logic [63:0] out_data;
   logic        dcache_r_rqst, dcache_r_done;
   logic [63:0] dcache_r_addr, dcache_r_data;
   logic [2:0]  dcache_r_bits;
   logic        dcache_w_rqst, dcache_w_done;
   logic [63:0] dcache_w_addr, dcache_w_data;
   logic [2:0]  dcache_w_bits;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] last_data;
   logic [4:0]  last_rd;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .ena(ena), .free(free),
      .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_result(in_result), .in_rdaddr(in_rdaddr),
      .out_valid(out_valid), .out_rdaddr(out_rdaddr), .out_data(out_data),
      .dcache_r_rqst(dcache_r_rqst), .dcache_r_addr(dcache_r_addr),
      .dcache_r_bits(dcache_r_bits), .dcache_r_done(dcache_r_done),
      .dcache_r_data(dcache_r_data),
      .dcache_w_rqst(dcache_w_rqst), .dcache_w_addr(dcache_w_addr),
      .dcache_w_bits(dcache_w_bits), .dcache_w_data(dcache_w_data),
      .dcache_w_done(dcache_w_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mask(input logic [2:0] f3);
      int nbits;
      nbits = 8 << f3[1:0];
      if (nbits == 64) return 64'hFFFF_FFFF_FFFF_FFFF;
      return (64'd1 << nbits) - 64'd1;
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] f3);
      int nbits;
      logic [63:0] v;
      nbits = 8 << f3[1:0];
      if (nbits == 64) return d;
      v = d & ref_mask(f3);
      if (!f3[2] && d[nbits-1]) v = v | ~ref_mask(f3);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete operation: accept, optional cache handshake, completion, hold.
   task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] result, input logic [4:0] rd,
                        input logic [63:0] rdata, input int delay);
      bit is_ld, is_st;
      logic [63:0] exp;
      is_ld = ld;
      is_st = st && !ld;
      chk("free_before", {63'd0, free}, 64'd1);
      ena = 1'b1; in_valid = 1'b1; in_load = ld; in_store = st;
      in_funct3 = f3; in_addr = addr; in_wdata = wdata; in_result = result; in_rdaddr = rd;
      tick();
      in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      in_result = {$urandom, $urandom}; in_rdaddr = 5'($urandom);
      if (!is_ld && !is_st) begin
         chk("alu_valid", {63'd0, out_valid}, 64'd1);
         chk("alu_data", out_data, result);
         chk("alu_rd", {59'd0, out_rdaddr}, {59'd0, rd});
         chk("alu_free", {63'd0, free}, 64'd1);
         last_data = result;
         last_rd = rd;
      end else begin
         chk("issue_rqst", {63'd0, is_ld ? dcache_r_rqst : dcache_w_rqst}, 64'd1);
         chk("issue_other", {63'd0, is_ld ? dcache_w_rqst : dcache_r_rqst}, 64'd0);
         chk("issue_free", {63'd0, free}, 64'd0);
         chk("issue_addr", is_ld ? dcache_r_addr : dcache_w_addr, addr);
         chk("issue_bits", {61'd0, is_ld ? dcache_r_bits : dcache_w_bits}, {61'd0, f3});
         if (is_st) chk("store_wdata", dcache_w_data, wdata & ref_mask(f3));
         // A matching done during ISSUE must be ignored.
         if (is_ld) begin dcache_r_done = 1'b1; dcache_r_data = ~rdata; end
         else dcache_w_done = 1'b1;
         tick();
         dcache_r_done = 1'b0; dcache_w_done = 1'b0;
         for (int i = 0; i < delay; i++) begin
            chk("wait_rqst", {63'd0, dcache_r_rqst | dcache_w_rqst}, 64'd0);
            chk("wait_valid", {63'd0, out_valid}, 64'd0);
            chk("wait_free", {63'd0, free}, 64'd0);
            chk("wait_addr", is_ld ? dcache_r_addr : dcache_w_addr, addr);
            if (is_ld) dcache_w_done = 1'b1; else dcache_r_done = 1'b1;
            tick();
            dcache_r_done = 1'b0; dcache_w_done = 1'b0;
         end
         chk("wait_rqst", {63'd0, dcache_r_rqst | dcache_w_rqst}, 64'd0);
         chk("wait_free", {63'd0, free}, 64'd0);
         if (is_ld) begin dcache_r_done = 1'b1; dcache_r_data = rdata; end
         else dcache_w_done = 1'b1;
         tick();
         dcache_r_done = 1'b0; dcache_w_done = 1'b0; dcache_r_data = {$urandom, $urandom};
         exp = is_ld ? ref_load(rdata, f3) : 64'd0;
         chk("mem_valid", {63'd0, out_valid}, 64'd1);
         chk("mem_data", out_data, exp);
         chk("mem_rd", {59'd0, out_rdaddr}, is_ld ? {59'd0, rd} : 64'd0);
         chk("mem_free", {63'd0, free}, 64'd1);
         last_data = exp;
         last_rd = is_ld ? rd : 5'd0;
      end
      tick();
      chk("hold_valid", {63'd0, out_valid}, 64'd0);
      chk("hold_data", out_data, last_data);
      chk("hold_rd", {59'd0, out_rdaddr}, {59'd0, last_rd});
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      in_funct3 = 3'd0; in_addr = 64'd0; in_wdata = 64'd0; in_result = 64'd0;
      in_rdaddr = 5'd0; dcache_r_done = 1'b0; dcache_r_data = 64'd0; dcache_w_done = 1'b0;
      last_data = 64'd0; last_rd = 5'd0;
      #12;
      chk("rst_free", {63'd0, free}, 64'd1);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_rqst", {63'd0, dcache_r_rqst | dcache_w_rqst}, 64'd0);
      chk("rst_wdata", dcache_w_data, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Directed cases: LB sign extension, LWU, SH masking.
      do_op(1'b1, 1'b0, 3'b000, 64'h1000, 64'd0, 64'd0, 5'd5, 64'h80, 2);
      chk("lb_const", last_data, 64'hFFFF_FFFF_FFFF_FF80);
      do_op(1'b1, 1'b0, 3'b110, 64'h1008, 64'd0, 64'd0, 5'd6, 64'hDEAD_BEEF_8765_4321, 0);
      chk("lwu_const", last_data, 64'h0000_0000_8765_4321);
      do_op(1'b0, 1'b1, 3'b001, 64'h2002, 64'h1234_5678_9ABC, 64'd0, 5'd7, 64'd0, 1);
      do_op(1'b1, 1'b1, 3'b011, 64'h3000, 64'd0, 64'd0, 5'd9, 64'h8123_4567_89AB_CDEF, 0);

      // Back-to-back ALU results 5 then 7.
      ena = 1'b1; in_valid = 1'b1; in_load = 1'b0; in_store = 1'b0;
      in_result = 64'd5; in_rdaddr = 5'd3;
      tick();
      chk("b2b_first", out_data, 64'd5);
      chk("b2b_first_v", {63'd0, out_valid}, 64'd1);
      in_result = 64'd7; in_rdaddr = 5'd4;
      tick();
      in_valid = 1'b0;
      chk("b2b_second", out_data, 64'd7);
      chk("b2b_second_v", {63'd0, out_valid}, 64'd1);
      tick();
      chk("b2b_after_v", {63'd0, out_valid}, 64'd0);
      last_data = 64'd7; last_rd = 5'd4;

      // ena low blocks acceptance.
      ena = 1'b0; in_valid = 1'b1; in_load = 1'b1;
      tick();
      in_valid = 1'b0; in_load = 1'b0; ena = 1'b1;
      chk("ena_rqst", {63'd0, dcache_r_rqst}, 64'd0);
      chk("ena_free", {63'd0, free}, 64'd1);
      chk("ena_valid", {63'd0, out_valid}, 64'd0);

      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = $urandom_range(0, 3);
         do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               5'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
      end

      // Spurious done in IDLE, then reset abandons a load in RD_WAIT.
      do_op(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 64'hABCD, 5'd11, 64'd0, 0);
      dcache_r_done = 1'b1; dcache_r_data = 64'h55; dcache_w_done = 1'b1;
      tick();
      dcache_r_done = 1'b0; dcache_w_done = 1'b0;
      chk("spur_valid", {63'd0, out_valid}, 64'd0);
      chk("spur_free", {63'd0, free}, 64'd1);
      ena = 1'b1; in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b011; in_addr = 64'h4000;
      tick();
      in_valid = 1'b0; in_load = 1'b0;
      tick();
      chk("pre_rst_free", {63'd0, free}, 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_free", {63'd0, free}, 64'd1);
      chk("arst_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_data", out_data, 64'd0);
      chk("arst_rd", {59'd0, out_rdaddr}, 64'd0);
      chk("arst_addr", dcache_r_addr, 64'd0);
      chk("arst_bits", {61'd0, dcache_r_bits}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dcache_r_done = 1'b1; dcache_r_data = 64'h1234;
      tick();
      dcache_r_done = 1'b0;
      chk("late_done_valid", {63'd0, out_valid}, 64'd0);
      tick();
      chk("late_done_valid2", {63'd0, out_valid}, 64'd0);
      chk("late_done_data", out_data, 64'd0);
      chk("late_done_free", {63'd0, free}, 64'd1);
      chk("late_done_rqst", {63'd0, dcache_r_rqst}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
